// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, channel state type and counter width helper for debounce_multi
package debounce_pkg;

    localparam int CLK_HZ         = 50000000;
    localparam int DEFAULT_STABLE = 10000;
    localparam int DEFAULT_SYNC   = 2;

    // Per-channel relationship between the synchronised input and the clean level
    typedef enum logic {
        ST_MATCH   = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability counter, edge pulses, optional hold counter (DEBOUNCE_LONGPRESS_EN)
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE,
    parameter int   SYNC_STAGES   = DEFAULT_SYNC,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   LONG_CYCLES   = CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic bouncy_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic edge_next,
    output logic long_press
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    chan_state_e            state;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin into the synchroniser and decide whether the clean level may follow it
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], bouncy_in};
        state   = (s == clean_q) ? ST_MATCH : ST_PENDING;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state)
            ST_MATCH: cnt_d = '0;
            ST_PENDING: begin
                if (tick) begin
                    if (cnt_q >= CNT_LAST) begin
                        clean_d = s;
                        cnt_d   = '0;
                        rise_d  = s;
                        fall_d  = ~s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Channel state registers; reset puts the synchroniser and clean level at RESET_VAL so no edge is seen on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_next  = rise_d | fall_d;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int            HW        = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Count ticks while the clean level is high; park past the last value so each press pulses once
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!clean_q) begin
            hold_d = '0;
        end else if (tick && (hold_q == HOLD_LAST)) begin
            hold_d = HOLD_DONE;
            long_d = 1'b1;
        end else if (tick && (hold_q < HOLD_LAST)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter and long-press pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel debouncer top; long-press output enabled by DEBOUNCE_LONGPRESS_EN
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int              N_CH          = 4,
    parameter int              STABLE_CYCLES = DEFAULT_STABLE,
    parameter int              SYNC_STAGES   = DEFAULT_SYNC,
    parameter logic [N_CH-1:0] RESET_VAL     = '0,
    parameter int              LONG_CYCLES   = CLK_HZ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] bouncy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change,
    output logic [N_CH-1:0] long_press
);

    logic [N_CH-1:0] edge_next;
    logic            any_change_q, any_change_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_VAL     (RESET_VAL[i]),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .bouncy_in  (bouncy_in[i]),
            .clean_out  (clean_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .edge_next  (edge_next[i]),
            .long_press (long_press[i])
        );
    end

    // any_change is computed from the channels' next-cycle pulses so it lands on the same edge as them
    always_comb begin
        any_change_d = |edge_next;
    end

    // Registered summary pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi with two reset-value variants
module tb_debounce_multi;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam int LONG   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [1:0] in_a = 2'b00;
    logic [1:0] in_b = 2'b11;
    logic [1:0] clean_a, rise_a, fall_a, long_a;
    logic [1:0] clean_b, rise_b, fall_b, long_b;
    logic       any_a, any_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(2), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .RESET_VAL(2'b00), .LONG_CYCLES(LONG)
    ) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .bouncy_in(in_a), .clean_out(clean_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a), .long_press(long_a)
    );

    debounce_multi #(
        .N_CH(2), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .RESET_VAL(2'b11), .LONG_CYCLES(LONG)
    ) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .bouncy_in(in_b), .clean_out(clean_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b), .long_press(long_b)
    );

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lp;
        logic       any;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    pair_t exp_q[$];

    // Reference model: input history per channel, clean level, and count of qualifying ticks in the current mismatch run
    logic [7:0] m_hist  [2][2];
    logic       m_clean [2][2];
    int         m_run   [2][2];
    int         m_held  [2][2];
    bit         m_fired [2][2];
    logic [1:0] m_rv    [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_hist[d][c]  = {8{m_rv[d][c]}};
                m_clean[d][c] = m_rv[d][c];
                m_run[d][c]   = 0;
                m_held[d][c]  = 0;
                m_fired[d][c] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic [1:0] a, input logic [1:0] b, input logic t, input logic r,
                              output pair_t e);
        obs_t       eo [2];
        logic [1:0] inv [2];
        logic       s, was_high;
        inv[0] = a;
        inv[1] = b;
        if (r) model_reset();
        for (int d = 0; d < 2; d++) begin
            eo[d] = '0;
            for (int c = 0; c < 2; c++) begin
                if (!r) begin
                    m_hist[d][c] = {m_hist[d][c][6:0], inv[d][c]};
                    s = m_hist[d][c][SYNC];
                    was_high = m_clean[d][c];
                    if (s != m_clean[d][c]) begin
                        if (t) begin
                            m_run[d][c]++;
                            if (m_run[d][c] == STABLE) begin
                                m_clean[d][c] = s;
                                m_run[d][c]   = 0;
                                eo[d].rise[c] = s;
                                eo[d].fall[c] = ~s;
                            end
                        end
                    end else begin
                        m_run[d][c] = 0;
                    end
                    if (!was_high) begin
                        m_held[d][c]  = 0;
                        m_fired[d][c] = 1'b0;
                    end else if (t && !m_fired[d][c]) begin
                        m_held[d][c]++;
                        if (m_held[d][c] == LONG) begin
                            m_fired[d][c] = 1'b1;
`ifdef DEBOUNCE_LONGPRESS_EN
                            eo[d].lp[c] = 1'b1;
`endif
                        end
                    end
                end
                eo[d].clean[c] = m_clean[d][c];
            end
            eo[d].any = |(eo[d].rise | eo[d].fall);
        end
        e.a = eo[0];
        e.b = eo[1];
    endtask

    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic t, input logic r);
        pair_t e;
        @(negedge clk);
        in_a = a;
        in_b = b;
        tick = t;
        rst  = r;
        model_edge(a, b, t, r, e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, want);
        end
    endtask

    // Monitor: after every clock edge, pop the expected outputs for that edge and compare
    initial begin
        pair_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_clean", clean_a, e.a.clean);
                chk("a_rise", rise_a, e.a.rise);
                chk("a_fall", fall_a, e.a.fall);
                chk("a_long", long_a, e.a.lp);
                chk("a_any", {1'b0, any_a}, {1'b0, e.a.any});
                chk("b_clean", clean_b, e.b.clean);
                chk("b_rise", rise_b, e.b.rise);
                chk("b_fall", fall_b, e.b.fall);
                chk("b_long", long_b, e.b.lp);
                chk("b_any", {1'b0, any_b}, {1'b0, e.b.any});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [1:0] ra, rb;
        m_rv[0] = 2'b00;
        m_rv[1] = 2'b11;
        model_reset();

        repeat (3) step(2'b00, 2'b11, 1'b1, 1'b1);

        // clean step on channel 0
        repeat (12) step(2'b01, 2'b11, 1'b1, 1'b0);
        repeat (10) step(2'b00, 2'b11, 1'b1, 1'b0);

        // bounce 1,0,1,0 every two cycles, then hold high long enough for a long press
        for (int i = 0; i < 4; i++) begin
            repeat (2) step((i % 2 == 0) ? 2'b01 : 2'b00, 2'b11, 1'b1, 1'b0);
        end
        repeat (20) step(2'b01, 2'b11, 1'b1, 1'b0);
        repeat (10) step(2'b00, 2'b11, 1'b1, 1'b0);

        // short press: clean level high for only five cycles
        repeat (5) step(2'b01, 2'b11, 1'b1, 1'b0);
        repeat (12) step(2'b00, 2'b11, 1'b1, 1'b0);

        // tick one cycle in three, with a low glitch while tick is 0
        for (int k = 0; k < 30; k++) begin
            step((k == 7) ? 2'b00 : 2'b01, 2'b11, (k % 3 == 0), 1'b0);
        end
        for (int k = 0; k < 30; k++) begin
            step(2'b00, 2'b11, (k % 3 == 0), 1'b0);
        end
        repeat (4) step(2'b00, 2'b11, 1'b1, 1'b0);

        // both channels step together
        repeat (10) step(2'b11, 2'b11, 1'b1, 1'b0);
        repeat (10) step(2'b00, 2'b11, 1'b1, 1'b0);

        // reset two cycles into a pending count
        repeat (4) step(2'b11, 2'b11, 1'b1, 1'b0);
        repeat (2) step(2'b11, 2'b11, 1'b1, 1'b1);
        repeat (12) step(2'b00, 2'b11, 1'b1, 1'b0);

        // randomized levels, tick and occasional reset on both instances
        ra = 2'b00;
        rb = 2'b11;
        for (int k = 0; k < 500; k++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 5) == 0) ra[c] = ~ra[c];
                if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
            end
            step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
        end
        repeat (20) step(ra, rb, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel debouncer for buttons, switches and rotary-encoder contacts on the FPGA board.
- Each channel passes its asynchronous input through a resettable synchroniser, then a stability counter. It drives a clean level plus one-cycle rise and fall pulses.
- An optional tick input slows the stability timebase.
- Sits between board pins and user logic such as the rotary decoder and hex display control.

Parameters:
- N_CH, 4, number of independent channels.
- STABLE_CYCLES, 10000, consecutive qualifying cycles of mismatch required before the clean level changes; legal range is 1 or more.
- SYNC_STAGES, 2, synchroniser flop depth; legal range is 2 or more.
- RESET_VAL, '0 (N_CH bits), per-channel reset level of the synchroniser and the clean output.
- LONG_CYCLES, 50000000, qualifying cycles of high clean level before a long-press pulse; used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset: asynchronous, active-high.
- tick  in  1  timebase enable; tie to 1 to count every clk.
- bouncy_in  in  N_CH  raw asynchronous inputs.
- clean_out  out  N_CH  debounced levels.
- rise_pulse  out  N_CH  one-cycle pulse when clean_out goes 0 to 1.
- fall_pulse  out  N_CH  one-cycle pulse when clean_out goes 1 to 0.
- any_change  out  1  OR of all rise_pulse and fall_pulse bits, registered in the same cycle as those pulses.
- long_press  out  N_CH  one-cycle long-hold pulse; constant 0 unless the optional feature is enabled.

Behaviour:
- Reset (async assert, release sampled on clk):
  - Synchroniser flops and clean_out are set to RESET_VAL.
  - Counters are set to 0.
  - rise_pulse, fall_pulse, any_change and long_press are 0.
  - No edge pulse may fire on the first cycles after reset.
- Per channel, s = last synchroniser stage output.
- State per channel is the pair {MATCH, PENDING}.
- MATCH (s == clean_out):
  - Counter is held at 0.
- PENDING (s != clean_out):
  - If tick = 1 and counter < STABLE_CYCLES-1: counter increments.
  - If tick = 1 and counter == STABLE_CYCLES-1: clean_out <= s, counter <= 0, and rise_pulse or fall_pulse asserts for exactly 1 cycle, registered together with clean_out.
  - If tick = 0: counter holds.
- Any return to s == clean_out before the update clears the counter to 0 on that clock, whatever the tick value. Bounces restart the count.
- Latency from a clean input step with tick = 1: SYNC_STAGES + STABLE_CYCLES clk edges to the clean_out change.
- Counter width is $clog2(STABLE_CYCLES+1). The counter saturates by construction and never wraps.
- Channels are fully independent. Simultaneous updates on several channels each pulse in the same cycle, and any_change is 1 for that single cycle.
- Reset mid-count: all counts are discarded, clean_out returns to RESET_VAL, and no pulse fires.
- STABLE_CYCLES = 1: clean_out updates on the first tick cycle of mismatch.

Optional Feature:
- Macro: DEBOUNCE_LONGPRESS_EN.
- Defined:
  - A per-channel hold counter of width $clog2(LONG_CYCLES+1) counts tick cycles while clean_out is 1.
  - When it reaches LONG_CYCLES-1, long_press pulses for 1 cycle and the counter stops. There is one pulse per press.
  - The hold counter clears when clean_out is 0 or on reset.
- Undefined: long_press is tied to 0 and no hold counters are synthesised. Port list is unchanged.

Decomposition:
- Package debounce_pkg:
  - Default constants CLK_HZ = 50000000, DEFAULT_STABLE = 10000, DEFAULT_SYNC = 2.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module debounce_chan:
  - Owns one channel: synchroniser, stability counter, clean level, edge pulses, and the optional hold counter.
  - Instantiated N_CH times in a generate loop.
  - Top level only forms any_change and fans out tick.

Test Plan:
- Setup: N_CH=2, STABLE_CYCLES=4, SYNC_STAGES=2, RESET_VAL=2'b00, tick=1.
- Clean step: bouncy_in[0] 0 to 1 and held -> clean_out[0]=1 exactly 6 clk edges later; rise_pulse[0] and any_change high for 1 cycle at that edge; channel 1 unaffected.
- Bounce: bouncy_in[0] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no clean_out change during bouncing; clean_out[0]=1 6 edges after the final hold begins; exactly one rise_pulse.
- Tick gating: tick high 1 cycle in 3, input held 1 -> clean_out updates on the 4th tick after mismatch is visible; a glitch back to 0 while tick=0 still restarts the count.
- Simultaneous and reset: both channels step together -> both rise_pulse bits in the same cycle and any_change a single-cycle pulse. Assert rst 2 cycles into a pending count -> clean_out=00 and no pulses after release.
- RESET_VAL=2'b11 with inputs held 1 through reset -> no fall_pulse or rise_pulse after release.
- With DEBOUNCE_LONGPRESS_EN and LONG_CYCLES=8:
  - Hold high -> one long_press[0] pulse 8 cycles after the clean_out rise, none after that.
  - Release at 5 cycles -> no long_press.
